pc_fetch_ctrl: RTL and testbench

//  Owns the MIPS program counter and sequences instruction fetch over a req/ack imem port.

---
 rtl/pc_fetch_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: owns the MIPS program counter and sequences instruction
// fetch over a req/ack instruction-memory port.
//
// The next PC is sequential (+4), a branch or jump target, or the exception
// vector. The PC is held while the pipeline stalls. A response that arrives
// after a redirect is dropped, so it never produces instr_valid.
//
// Ports
//   clk            clock; all logic is on posedge
//   rst            synchronous, active-low reset
//   stall          pipeline cannot accept a new instruction
//   branch_taken   pulse: redirect to branch_target
//   branch_target  branch destination (bits [1:0] ignored)
//   jump           pulse: redirect to jump_target
//   jump_target    jump destination (bits [1:0] ignored)
//   exception      pulse: redirect to EXC_VECTOR and save epc
//   imem_req       fetch request, held until imem_ack
//   imem_addr      fetch address, always equal to pc
//   imem_ack       pulse: imem data valid this cycle
//   instr_valid    pulse: fetched word is good for the pipeline
//   pc             address of the current fetch or held instruction
//   epc            pc captured on exception or fetch timeout
//   fetch_err      pulse on fetch timeout
module pc_fetch_ctrl #(
   parameter int unsigned             WORD_SIZE    = 32,
   parameter logic [WORD_SIZE-1:0]    RESET_VECTOR = 32'h0000_0000,
   parameter logic [WORD_SIZE-1:0]    EXC_VECTOR   = 32'h8000_0180,
   parameter int unsigned             TIMEOUT      = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 branch_taken,
   input  logic [WORD_SIZE-1:0] branch_target,
   input  logic                 jump,
   input  logic [WORD_SIZE-1:0] jump_target,
   input  logic                 exception,
   output logic                 imem_req,
   output logic [WORD_SIZE-1:0] imem_addr,
   input  logic                 imem_ack,
   output logic                 instr_valid,
   output logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] epc,
   output logic                 fetch_err
);

   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PRIO_W = 2;

   localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'(3));
   localparam logic [CNT_W-1:0]     CNT_LIMIT  = CNT_W'(TIMEOUT);

   // Redirect priorities; a higher value wins.
   localparam logic [PRIO_W-1:0] PRIO_BRANCH = PRIO_W'(1);
   localparam logic [PRIO_W-1:0] PRIO_JUMP   = PRIO_W'(2);
   localparam logic [PRIO_W-1:0] PRIO_EXC    = PRIO_W'(3);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state,       state_d;
   logic [WORD_SIZE-1:0] pc_d,        epc_d;
   logic                 redir_pend,  redir_pend_d;
   logic [WORD_SIZE-1:0] redir_addr,  redir_addr_d;
   logic [PRIO_W-1:0]    redir_prio,  redir_prio_d;
   logic [CNT_W-1:0]     wait_cnt,    wait_cnt_d;
   logic                 imem_req_d;
   logic                 instr_valid_d;
   logic                 fetch_err_d;

   logic                 redir_now;
   logic [WORD_SIZE-1:0] redir_now_addr;
   logic [PRIO_W-1:0]    redir_now_prio;
   logic                 take_now;
   logic [WORD_SIZE-1:0] sel_addr;
   logic [WORD_SIZE-1:0] pc_seq;

   assign imem_addr = pc;
   assign pc_seq    = pc + WORD_SIZE'(4);

   // Highest-priority redirect requested this cycle; lower ones are lost.
   always_comb begin
      redir_now      = 1'b0;
      redir_now_addr = '0;
      redir_now_prio = '0;
      if (exception) begin
         redir_now      = 1'b1;
         redir_now_addr = EXC_VECTOR;
         redir_now_prio = PRIO_EXC;
      end else if (jump) begin
         redir_now      = 1'b1;
         redir_now_addr = jump_target & ALIGN_MASK;
         redir_now_prio = PRIO_JUMP;
      end else if (branch_taken) begin
         redir_now      = 1'b1;
         redir_now_addr = branch_target & ALIGN_MASK;
         redir_now_prio = PRIO_BRANCH;
      end
   end

   // A same-cycle redirect displaces a pending one of lower or equal priority.
   assign take_now = redir_now && (!redir_pend || (redir_now_prio >= redir_prio));
   assign sel_addr = take_now ? redir_now_addr : redir_addr;

   // Next-state and next-output logic.
   always_comb begin
      state_d       = state;
      pc_d          = pc;
      epc_d         = epc;
      redir_pend_d  = redir_pend;
      redir_addr_d  = redir_addr;
      redir_prio_d  = redir_prio;
      wait_cnt_d    = wait_cnt;
      instr_valid_d = 1'b0;
      fetch_err_d   = 1'b0;

      if (exception) begin
         epc_d = pc;
      end

      unique case (state)
         IDLE: begin
            // A late ack from before reset is ignored here.
            state_d    = REQ;
            wait_cnt_d = '0;
            if (redir_now) begin
               pc_d = redir_now_addr;
            end
         end

         REQ: begin
            if (imem_ack) begin
               wait_cnt_d   = '0;
               redir_pend_d = 1'b0;
               if (redir_now || redir_pend) begin
                  // Response belongs to a fetch that was redirected: drop it.
                  pc_d = sel_addr;
               end else begin
                  instr_valid_d = 1'b1;
                  if (stall) begin
                     state_d = HOLD;
                  end else begin
                     pc_d = pc_seq;
                  end
               end
            end else if (wait_cnt == CNT_LIMIT) begin
               fetch_err_d  = 1'b1;
               epc_d        = pc;
               pc_d         = EXC_VECTOR;
               redir_pend_d = 1'b0;
               wait_cnt_d   = '0;
            end else begin
               wait_cnt_d = wait_cnt + CNT_W'(1);
               if (take_now) begin
                  redir_pend_d = 1'b1;
                  redir_addr_d = redir_now_addr;
                  redir_prio_d = redir_now_prio;
               end
            end
         end

         HOLD: begin
            // A redirect overrides the stall.
            if (redir_now) begin
               pc_d       = redir_now_addr;
               state_d    = REQ;
               wait_cnt_d = '0;
            end else if (!stall) begin
               pc_d       = pc_seq;
               state_d    = REQ;
               wait_cnt_d = '0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      imem_req_d = (state_d == REQ);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         pc          <= RESET_VECTOR;
         epc         <= '0;
         redir_pend  <= 1'b0;
         redir_addr  <= '0;
         redir_prio  <= '0;
         wait_cnt    <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         state       <= state_d;
         pc          <= pc_d;
         epc         <= epc_d;
         redir_pend  <= redir_pend_d;
         redir_addr  <= redir_addr_d;
         redir_prio  <= redir_prio_d;
         wait_cnt    <= wait_cnt_d;
         imem_req    <= imem_req_d;
         instr_valid <= instr_valid_d;
         fetch_err   <= fetch_err_d;
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: inputs are driven and outputs sampled
// on the falling edge, with expected values worked out by hand.
module tb_pc_fetch_ctrl;

   localparam int unsigned W          = 32;
   localparam logic [W-1:0] RST_VEC   = 32'h0000_0000;
   localparam logic [W-1:0] EXC_VEC   = 32'h8000_0180;
   localparam int unsigned TMO        = 15;

   logic         clk = 1'b0;
   logic         rst;
   logic         stall;
   logic         branch_taken;
   logic [W-1:0] branch_target;
   logic         jump;
   logic [W-1:0] jump_target;
   logic         exception;
   logic         imem_req;
   logic [W-1:0] imem_addr;
   logic         imem_ack;
   logic         instr_valid;
   logic [W-1:0] pc;
   logic [W-1:0] epc;
   logic         fetch_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .WORD_SIZE    (W),
      .RESET_VECTOR (RST_VEC),
      .EXC_VECTOR   (EXC_VEC),
      .TIMEOUT      (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .exception     (exception),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .epc           (epc),
      .fetch_err     (fetch_err)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = '0;
      jump          = 1'b0;
      jump_target   = '0;
      exception     = 1'b0;
      imem_ack      = 1'b0;
   endtask

   // Leaves the DUT in REQ at pc=RESET_VECTOR.
   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      n_vec++; if (pc !== RST_VEC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_VEC); end
      n_vec++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
      n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_vec++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", fetch_err); end
      rst = 1'b1;
      tick();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== RST_VEC) begin n_err++; $display("FAIL release_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RST_VEC); end
   endtask

   task automatic test_sequential();
      logic [W-1:0] exp_a;
      for (int i = 0; i < 4; i++) begin
         exp_a = W'(i * 4);
         n_vec++; if (imem_req !== 1'b1 || imem_addr !== exp_a) begin n_err++; $display("FAIL seq_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, exp_a); end
         tick();
         n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL seq_wait_valid[%0d]: got %b want 0", i, instr_valid); end
         imem_ack = 1'b1;
         tick();
         imem_ack = 1'b0;
         n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid[%0d]: got %b want 1", i, instr_valid); end
      end
      n_vec++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL seq_end_addr: got %h want 00000010", imem_addr); end
   endtask

   task automatic test_stall();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         imem_ack = 1'b1;
         tick();
         imem_ack = 1'b0;
      end
      n_vec++; if (pc !== 32'h8) begin n_err++; $display("FAIL stall_pre_pc: got %h want 00000008", pc); end
      stall    = 1'b1;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
      n_vec++; if (imem_req !== 1'b0 || pc !== 32'h8) begin n_err++; $display("FAIL stall_hold: got req=%b pc=%h want req=0 pc=00000008", imem_req, pc); end
      tick();
      tick();
      n_vec++; if (imem_req !== 1'b0 || pc !== 32'h8 || instr_valid !== 1'b0) begin n_err++; $display("FAIL stall_held: got req=%b pc=%h valid=%b want 0/00000008/0", imem_req, pc, instr_valid); end
      stall = 1'b0;
      tick();
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_err++; $display("FAIL stall_resume: got req=%b addr=%h want req=1 addr=0000000c", imem_req, imem_addr); end
   endtask

   task automatic test_branch_discard();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (pc !== 32'h10) begin n_err++; $display("FAIL br_pre_pc: got %h want 00000010", pc); end
      branch_taken  = 1'b1;
      branch_target = 32'h43;
      tick();
      branch_taken  = 1'b0;
      n_vec++; if (pc !== 32'h10 || imem_req !== 1'b1) begin n_err++; $display("FAIL br_pending: got pc=%h req=%b want 00000010/1", pc, imem_req); end
      tick();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL br_discard_valid: got %b want 0", instr_valid); end
      n_vec++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin n_err++; $display("FAIL br_target: got addr=%h req=%b want 00000040/1", imem_addr, imem_req); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h44) begin n_err++; $display("FAIL br_after: got valid=%b pc=%h want 1/00000044", instr_valid, pc); end
   endtask

   task automatic test_exception_priority();
      branch_taken  = 1'b1;
      branch_target = 32'h20;
      imem_ack      = 1'b1;
      tick();
      clear_inputs();
      n_vec++; if (pc !== 32'h20 || instr_valid !== 1'b0) begin n_err++; $display("FAIL exc_pre: got pc=%h valid=%b want 00000020/0", pc, instr_valid); end
      exception   = 1'b1;
      jump        = 1'b1;
      jump_target = 32'h100;
      imem_ack    = 1'b1;
      tick();
      clear_inputs();
      n_vec++; if (epc !== 32'h20) begin n_err++; $display("FAIL exc_epc: got %h want 00000020", epc); end
      n_vec++; if (pc !== EXC_VEC || instr_valid !== 1'b0) begin n_err++; $display("FAIL exc_pc: got pc=%h valid=%b want %h/0", pc, instr_valid, EXC_VEC); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (pc !== 32'h8000_0184 || instr_valid !== 1'b1) begin n_err++; $display("FAIL exc_after: got pc=%h valid=%b want 80000184/1", pc, instr_valid); end
   endtask

   task automatic test_pending_priority();
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      tick();
      branch_taken  = 1'b0;
      jump          = 1'b1;
      jump_target   = 32'h300;
      tick();
      jump          = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h400;
      tick();
      clear_inputs();
      n_vec++; if (pc !== 32'h8000_0184) begin n_err++; $display("FAIL pend_pc_held: got %h want 80000184", pc); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (pc !== 32'h300 || instr_valid !== 1'b0) begin n_err++; $display("FAIL pend_prio: got pc=%h valid=%b want 00000300/0", pc, instr_valid); end
   endtask

   task automatic test_timeout();
      jump        = 1'b1;
      jump_target = 32'h30;
      imem_ack    = 1'b1;
      tick();
      clear_inputs();
      n_vec++; if (pc !== 32'h30) begin n_err++; $display("FAIL tmo_pre_pc: got %h want 00000030", pc); end
      for (int i = 0; i < int'(TMO); i++) begin
         tick();
         n_vec++; if (fetch_err !== 1'b0 || pc !== 32'h30) begin n_err++; $display("FAIL tmo_wait[%0d]: got err=%b pc=%h want 0/00000030", i, fetch_err, pc); end
      end
      tick();
      n_vec++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", fetch_err); end
      n_vec++; if (epc !== 32'h30) begin n_err++; $display("FAIL tmo_epc: got %h want 00000030", epc); end
      n_vec++; if (imem_addr !== EXC_VEC || imem_req !== 1'b1) begin n_err++; $display("FAIL tmo_addr: got addr=%h req=%b want %h/1", imem_addr, imem_req, EXC_VEC); end
      tick();
      n_vec++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL tmo_pulse: got %b want 0", fetch_err); end
   endtask

   task automatic test_reset_mid_req();
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      n_vec++; if (pc !== RST_VEC || imem_req !== 1'b0 || epc !== 32'h0) begin n_err++; $display("FAIL rmid_state: got pc=%h req=%b epc=%h want %h/0/0", pc, imem_req, epc, RST_VEC); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== RST_VEC) begin n_err++; $display("FAIL rmid_late_ack: got valid=%b req=%b pc=%h want 0/1/%h", instr_valid, imem_req, pc, RST_VEC); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (instr_valid !== 1'b1 || pc !== 32'h4) begin n_err++; $display("FAIL rmid_restart: got valid=%b pc=%h want 1/00000004", instr_valid, pc); end
   endtask

   task automatic test_wrap();
      jump        = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      imem_ack    = 1'b1;
      tick();
      clear_inputs();
      n_vec++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre: got %h want fffffffc", pc); end
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (imem_addr !== 32'h0 || instr_valid !== 1'b1) begin n_err++; $display("FAIL wrap_addr: got addr=%h valid=%b want 00000000/1", imem_addr, instr_valid); end
   endtask

   task automatic test_hold_redirect();
      do_reset();
      stall    = 1'b1;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      n_vec++; if (imem_req !== 1'b0 || pc !== RST_VEC) begin n_err++; $display("FAIL hold_enter: got req=%b pc=%h want 0/%h", imem_req, pc, RST_VEC); end
      jump        = 1'b1;
      jump_target = 32'h81;
      tick();
      jump = 1'b0;
      n_vec++; if (imem_req !== 1'b1 || pc !== 32'h80 || instr_valid !== 1'b0) begin n_err++; $display("FAIL hold_redirect: got req=%b pc=%h valid=%b want 1/00000080/0", imem_req, pc, instr_valid); end
      stall = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b0;
      test_reset();
      test_sequential();
      test_stall();
      test_branch_discard();
      test_exception_priority();
      test_pending_priority();
      test_timeout();
      test_reset_mid_req();
      test_wrap();
      test_hold_redirect();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
